// File: rtl/ctrl_botones_sched.sv
// ctrl_botones_sched: schedules button commands for the time-field edit FSM.
// Each single-cycle tick from the up/down/left/right edge detectors is latched
// as a pending request. Pending requests are granted round-robin, one at a
// time, over a valid/ready handshake. After every accepted command, cmd_valid
// stays low for a fixed idle gap.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous active-high reset
//   tick_in    button ticks: [0]=up [1]=down [2]=left [3]=right
//   cmd_ready  consumer accepts the command this cycle
//   clr_drop   clears the sticky drop flags
//   cmd_valid  command available
//   cmd_code   index of the granted button
//   pend       registered pending request flags
//   drop       sticky flags: a tick arrived while that index was already pending
//   busy       scheduler is not idle
module ctrl_botones_sched #(
  parameter int unsigned GAP   = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] tick_in,
  input  logic       cmd_ready,
  input  logic       clr_drop,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic [3:0] pend,
  output logic [3:0] drop,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  localparam bit              GapIsZero = (GAP == 0);
  localparam logic [CNT_W-1:0] GapLoad  = GapIsZero ? '0 : CNT_W'(GAP - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         last_q, last_d;
  logic [1:0]         code_q, code_d;
  logic               valid_q, valid_d;
  logic [3:0]         pend_q, pend_d;
  logic [3:0]         drop_q, drop_d;
  logic [3:0]         grant;
  logic [1:0]         winner;
  logic [1:0]         idx;

  // Round-robin search from last+1. Iterating from the farthest offset down
  // means the nearest set bit is the final assignment.
  always_comb begin
    winner = last_q;
    idx    = last_q;
    for (int k = 4; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (pend_q[idx]) winner = idx;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    code_d  = code_q;
    valid_d = valid_q;
    grant   = 4'b0000;

    unique case (state_q)
      StIdle: begin
        // Only registered pend takes part; same-cycle ticks wait for next round.
        if (|pend_q) begin
          grant[winner] = 1'b1;
          code_d        = winner;
          last_d        = winner;
          valid_d       = 1'b1;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        if (cmd_ready) begin
          valid_d = 1'b0;
          if (GapIsZero) begin
            state_d = StIdle;
          end else begin
            cnt_d   = GapLoad;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // A tick on the grant edge of the same index re-arms the request.
    pend_d = tick_in | (pend_q & ~grant);
    // A new drop event wins over a simultaneous clear.
    drop_d = (clr_drop ? 4'b0000 : drop_q) | (tick_in & pend_q & ~grant);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      code_q  <= 2'd0;
      valid_q <= 1'b0;
      pend_q  <= 4'b0000;
      drop_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_code  = code_q;
  assign pend      = pend_q;
  assign drop      = drop_q;
  assign busy      = (state_q != StIdle);

endmodule
